// File: rtl/mul_pipe_vr_if.sv
// Handshake bundle for mul_pipe_vr: operand/tag request side and result side.
// master drives requests and out_ready; slave is the multiplier.
interface mul_pipe_vr_if #(
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int WIDTH_OUT = 32,
  parameter int TAG_W     = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_signed;
  logic [WIDTH_A-1:0]   in_a;
  logic [WIDTH_B-1:0]   in_b;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH_OUT-1:0] out_data;
  logic                 out_ovf;
  logic [TAG_W-1:0]     out_tag;

  modport master (
    output in_valid, in_signed, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_tag
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_tag
  );
endinterface

// File: rtl/mul_pipe_vr.sv
// Pipelined signed/unsigned multiplier with tag sideband, wrap or saturate; latency STAGES cycles.
// Whole pipe stalls when the output holds an unaccepted result; in_ready = out_ready | ~out_valid.
module mul_pipe_vr #(
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int WIDTH_OUT = 32,
  parameter int STAGES    = 3,
  parameter int TAG_W     = 4,
  parameter bit SATURATE  = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_pipe_vr_if.slave  bus
);
  localparam int WP = WIDTH_A + WIDTH_B;

  typedef struct packed {
    logic             vld;
    logic             sgn;
    logic             neg;
    logic [TAG_W-1:0] tag;
  } meta_t;

  logic                 w_adv;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH_A-1:0]   w_mag_a;
  logic [WIDTH_B-1:0]   w_mag_b;
  meta_t                w_meta_in;
  logic [WP-1:0]        w_fin_mag;
  meta_t                w_fin_meta;
  logic [WIDTH_OUT:0]   w_fin_res;

  logic                 r_out_vld;
  logic [WIDTH_OUT-1:0] r_out_data;
  logic                 r_out_ovf;
  logic [TAG_W-1:0]     r_out_tag;

  assign w_adv        = bus.out_ready | ~r_out_vld;
  assign bus.in_ready = w_adv;

  // Magnitudes stay at full operand width so the most-negative value loses nothing.
  assign w_a_neg   = bus.in_signed & bus.in_a[WIDTH_A-1];
  assign w_b_neg   = bus.in_signed & bus.in_b[WIDTH_B-1];
  assign w_mag_a   = w_a_neg ? (~bus.in_a + 1'b1) : bus.in_a;
  assign w_mag_b   = w_b_neg ? (~bus.in_b + 1'b1) : bus.in_b;
  assign w_meta_in = '{vld: bus.in_valid, sgn: bus.in_signed,
                       neg: w_a_neg ^ w_b_neg, tag: bus.in_tag};

  // Returns {ovf, data} from the unsigned magnitude product and its sign.
  function automatic logic [WIDTH_OUT:0] f_finish(input logic [WP-1:0] mag,
                                                   input logic sgn,
                                                   input logic neg);
    logic [WP-1:0]        p;
    logic                 ovf;
    logic [WIDTH_OUT-1:0] d;
    p   = neg ? (~mag + 1'b1) : mag;
    ovf = 1'b0;
    for (int i = WIDTH_OUT; i < WP; i++) begin
      if (sgn) ovf = ovf | (p[i] != p[WIDTH_OUT-1]);
      else     ovf = ovf | p[i];
    end
    d = p[WIDTH_OUT-1:0];
    if (SATURATE && ovf) begin
      if (!sgn)         d = '1;
      else if (p[WP-1]) d = {1'b1, {(WIDTH_OUT-1){1'b0}}};
      else              d = {1'b0, {(WIDTH_OUT-1){1'b1}}};
    end
    return {ovf, d};
  endfunction

  generate
    if (STAGES == 1) begin : g_s1
      assign w_fin_mag  = {{WIDTH_B{1'b0}}, w_mag_a} * {{WIDTH_A{1'b0}}, w_mag_b};
      assign w_fin_meta = w_meta_in;
    end else begin : g_sn
      logic [WIDTH_A-1:0] r_s1_a;
      logic [WIDTH_B-1:0] r_s1_b;
      meta_t              r_s1_meta;
      logic [WP-1:0]      w_s1_prod;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1_a    <= '0;
          r_s1_b    <= '0;
          r_s1_meta <= '0;
        end else if (w_adv) begin
          r_s1_a    <= w_mag_a;
          r_s1_b    <= w_mag_b;
          r_s1_meta <= w_meta_in;
        end
      end

      assign w_s1_prod = {{WIDTH_B{1'b0}}, r_s1_a} * {{WIDTH_A{1'b0}}, r_s1_b};

      if (STAGES == 2) begin : g_s2
        assign w_fin_mag  = w_s1_prod;
        assign w_fin_meta = r_s1_meta;
      end else begin : g_mid
        // Product is formed once and delayed; synthesis retiming spreads it over the middle stages.
        logic [WP-1:0] r_mid_p    [STAGES-1:2];
        meta_t         r_mid_meta [STAGES-1:2];

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int k = 2; k < STAGES; k++) begin
              r_mid_p[k]    <= '0;
              r_mid_meta[k] <= '0;
            end
          end else if (w_adv) begin
            r_mid_p[2]    <= w_s1_prod;
            r_mid_meta[2] <= r_s1_meta;
            for (int k = 3; k < STAGES; k++) begin
              r_mid_p[k]    <= r_mid_p[k-1];
              r_mid_meta[k] <= r_mid_meta[k-1];
            end
          end
        end

        assign w_fin_mag  = r_mid_p[STAGES-1];
        assign w_fin_meta = r_mid_meta[STAGES-1];
      end
    end
  endgenerate

  assign w_fin_res = f_finish(w_fin_mag, w_fin_meta.sgn, w_fin_meta.neg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_ovf  <= 1'b0;
      r_out_tag  <= '0;
    end else if (w_adv) begin
      r_out_vld  <= w_fin_meta.vld;
      r_out_data <= w_fin_res[WIDTH_OUT-1:0];
      r_out_ovf  <= w_fin_res[WIDTH_OUT];
      r_out_tag  <= w_fin_meta.tag;
    end
  end

  assign bus.out_valid = r_out_vld;
  assign bus.out_data  = r_out_data;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.out_tag   = r_out_tag;
endmodule
